// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared Wishbone response type and lane/offset helpers
package wb_pkg;

   localparam int unsigned WB_DATA_WIDTH = 32;
   localparam int unsigned WB_SEL_WIDTH  = WB_DATA_WIDTH / 8;
   localparam int unsigned WB_SEL_IDX_W  = $clog2(WB_SEL_WIDTH);

   typedef struct packed {
      logic                     valid;
      logic                     err;
      logic [WB_DATA_WIDTH-1:0] data;
   } wb_resp_t;

   function automatic int unsigned wb_off_bits(input int unsigned data_width);
      return $clog2(data_width / 8);
   endfunction

   // Each sel bit covers 'gran' data bits; unused upper sel bits must be zero.
   function automatic logic [WB_DATA_WIDTH-1:0] wb_lane_mask(
      input logic [WB_SEL_WIDTH-1:0] sel,
      input int unsigned             gran
   );
      logic [WB_DATA_WIDTH-1:0] mask;
      mask = '0;
      for (int unsigned i = 0; i < WB_DATA_WIDTH; i++) begin
         mask[i] = sel[WB_SEL_IDX_W'(i / gran)];
      end
      return mask;
   endfunction

endpackage

// File: rtl/wb_p_resp_pipe.sv
// rtl/wb_p_resp_pipe.sv - fixed-latency response shift register with synchronous flush
module wb_p_resp_pipe
   import wb_pkg::*;
#(
   parameter int unsigned LATENCY = 2
) (
   input  logic     clk_i,
   input  logic     rst_ni,
   input  logic     flush_i,
   input  wb_resp_t resp_i,
   output wb_resp_t resp_o
);

   wb_resp_t stage_q [LATENCY];
   wb_resp_t stage_d [LATENCY];

   always_comb begin
      for (int i = 0; i < LATENCY; i++) begin
         stage_d[i] = '0;
      end
      if (!flush_i) begin
         stage_d[0] = resp_i;
         for (int i = 1; i < LATENCY; i++) begin
            stage_d[i] = stage_q[i-1];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < LATENCY; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q <= stage_d;
      end
   end

   assign resp_o = stage_q[LATENCY-1];

endmodule

// File: rtl/wb_p_ram_slave.sv
// rtl/wb_p_ram_slave.sv - pipelined Wishbone RAM responder
// WB_P_RAM_SLAVE_STALL_INJECT_EN adds LFSR-driven random stall for master stress.
module wb_p_ram_slave
   import wb_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH      = 32,
   parameter int unsigned           ADDR_WIDTH      = 32,
   parameter int unsigned           GRANULARITY     = 8,
   parameter int unsigned           DEPTH           = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
   parameter int unsigned           READ_LATENCY    = 2,
   parameter int unsigned           MAX_OUTSTANDING = 4
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic [ADDR_WIDTH-1:0]             wb_adr_i,
   input  logic [DATA_WIDTH-1:0]             wb_dat_i,
   input  logic                              wb_we_i,
   input  logic [DATA_WIDTH/GRANULARITY-1:0] wb_sel_i,
   input  logic                              wb_stb_i,
   input  logic                              wb_cyc_i,
   output logic [DATA_WIDTH-1:0]             wb_dat_o,
   output logic                              wb_ack_o,
   output logic                              wb_err_o,
   output logic                              wb_stall_o
);

   localparam int unsigned BYTES     = DATA_WIDTH / 8;
   localparam int unsigned OFF_BITS  = wb_off_bits(DATA_WIDTH);
   localparam int unsigned WORD_BITS = $clog2(DEPTH);
   localparam int unsigned CNT_W     = $clog2(MAX_OUTSTANDING + 2);

   if (!(GRANULARITY == 8 || GRANULARITY == 16 || GRANULARITY == 32)) begin : g_bad_gran
      $fatal(1, "wb_p_ram_slave: GRANULARITY must be 8, 16 or 32");
   end
   if ((DATA_WIDTH % GRANULARITY) != 0 || DATA_WIDTH > WB_DATA_WIDTH) begin : g_bad_dw
      $fatal(1, "wb_p_ram_slave: DATA_WIDTH must be a multiple of GRANULARITY and fit wb_resp_t");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $fatal(1, "wb_p_ram_slave: DEPTH must be a power of two");
   end
   if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_lat
      $fatal(1, "wb_p_ram_slave: READ_LATENCY must be 1..4");
   end
   if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > READ_LATENCY + 1) begin : g_bad_out
      $fatal(1, "wb_p_ram_slave: MAX_OUTSTANDING must be 1..READ_LATENCY+1");
   end
   if ((BASE_ADDR & ADDR_WIDTH'(DEPTH * BYTES - 1)) != '0) begin : g_bad_base
      $fatal(1, "wb_p_ram_slave: BASE_ADDR must be aligned to the RAM size");
   end

   logic [DATA_WIDTH-1:0]    mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0]    offset;
   logic [WORD_BITS-1:0]     word;
   logic                     misaligned;
   logic                     out_of_range;
   logic                     req_err;
   logic                     accept;
   logic                     wr_en;
   logic [WB_DATA_WIDTH-1:0] lane_mask_full;
   logic [DATA_WIDTH-1:0]    lane_mask;
   logic [DATA_WIDTH-1:0]    rd_data;
   logic [DATA_WIDTH-1:0]    wr_data;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     rdy_q, rdy_d;
   logic                     stall_inject;
   wb_resp_t                 resp_in;
   wb_resp_t                 resp_out;

   always_comb begin
      offset         = wb_adr_i - BASE_ADDR;
      word           = offset[OFF_BITS +: WORD_BITS];
      misaligned     = (offset & ADDR_WIDTH'(BYTES - 1)) != '0;
      out_of_range   = (offset >> (OFF_BITS + WORD_BITS)) != '0;
      accept         = wb_cyc_i & wb_stb_i & ~wb_stall_o;
      req_err        = out_of_range | misaligned | (wb_we_i & (wb_sel_i == '0));
      wr_en          = accept & wb_we_i & ~req_err;
      lane_mask_full = wb_lane_mask(WB_SEL_WIDTH'(wb_sel_i), GRANULARITY);
      lane_mask      = lane_mask_full[DATA_WIDTH-1:0];
      rd_data        = mem_q[word];
      wr_data        = (rd_data & ~lane_mask) | (wb_dat_i & lane_mask);

      // Only successful reads carry data so dat_o stays 0 for writes and errors.
      resp_in        = '0;
      resp_in.valid  = accept;
      resp_in.err    = accept & req_err;
      if (accept && !wb_we_i && !req_err) begin
         resp_in.data = WB_DATA_WIDTH'(rd_data);
      end
   end

   always_comb begin
      rdy_d = 1'b1;
      cnt_d = cnt_q;
      if (!wb_cyc_i) begin
         cnt_d = '0;
      end else if (accept && !resp_out.valid) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (!accept && resp_out.valid) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         rdy_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         rdy_q <= rdy_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem_q[word] <= wr_data;
      end
   end

`ifdef WB_P_RAM_SLAVE_STALL_INJECT_EN
   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign stall_inject = lfsr_q[0];
`else
   assign stall_inject = 1'b0;
`endif

   assign wb_stall_o = ~rdy_q | (cnt_q >= CNT_W'(MAX_OUTSTANDING)) | stall_inject;

   wb_p_resp_pipe #(
      .LATENCY (READ_LATENCY)
   ) u_resp_pipe (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (~wb_cyc_i),
      .resp_i  (resp_in),
      .resp_o  (resp_out)
   );

   assign wb_ack_o = resp_out.valid & ~resp_out.err;
   assign wb_err_o = resp_out.valid & resp_out.err;
   assign wb_dat_o = wb_ack_o ? resp_out.data[DATA_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_wb_p_ram_slave.sv
// tb/tb_wb_p_ram_slave.sv - scoreboard bench for wb_p_ram_slave (MAX_OUTSTANDING 4 and 1)
module tb_wb_p_ram_slave;

   localparam logic [31:0] A_BASE = 32'h0001_0000;

   typedef struct {
      logic        err;
      logic [31:0] dat;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] adr [2];
   logic [31:0] wdat [2];
   logic [31:0] rdat [2];
   logic [3:0]  sel [2];
   logic        we [2];
   logic        stb [2];
   logic        cyc [2];
   logic        ack [2];
   logic        err [2];
   logic        stall [2];

   exp_t sb [2][$];
   int   n_tests = 0;
   int   n_fail = 0;
   int   cyc_cnt = 0;
   int   stall_seen [2] = '{0, 0};
   int   s0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   wb_p_ram_slave #(
      .BASE_ADDR (A_BASE), .READ_LATENCY (2), .MAX_OUTSTANDING (4)
   ) u_a (
      .clk_i (clk), .rst_ni (rst_n),
      .wb_adr_i (adr[0]), .wb_dat_i (wdat[0]), .wb_we_i (we[0]), .wb_sel_i (sel[0]),
      .wb_stb_i (stb[0]), .wb_cyc_i (cyc[0]), .wb_dat_o (rdat[0]), .wb_ack_o (ack[0]),
      .wb_err_o (err[0]), .wb_stall_o (stall[0])
   );

   wb_p_ram_slave #(
      .BASE_ADDR (32'h0), .READ_LATENCY (2), .MAX_OUTSTANDING (1)
   ) u_b (
      .clk_i (clk), .rst_ni (rst_n),
      .wb_adr_i (adr[1]), .wb_dat_i (wdat[1]), .wb_we_i (we[1]), .wb_sel_i (sel[1]),
      .wb_stb_i (stb[1]), .wb_cyc_i (cyc[1]), .wb_dat_o (rdat[1]), .wb_ack_o (ack[1]),
      .wb_err_o (err[1]), .wb_stall_o (stall[1])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic issue(input int b, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic e_err, input logic [31:0] e_dat);
      exp_t e;
      int   n;
      cyc[b] = 1'b1; stb[b] = 1'b1; we[b] = w; adr[b] = a; wdat[b] = d; sel[b] = s;
      @(negedge clk);
      n = 0;
      while (stall[b] && n < 50) begin
         stall_seen[b]++;
         @(negedge clk);
         n++;
      end
      check("accept_timeout", 32'(n < 50), 1);
      e.err = e_err;
      e.dat = e_dat;
      e.due = cyc_cnt + 2;
      sb[b].push_back(e);
      @(posedge clk);
      #1;
      if (b == 1) check("b_stall_after_acc", 32'(stall[1]), 1);
   endtask

   task automatic idle(input int b);
      stb[b] = 1'b0;
      we[b]  = 1'b0;
   endtask

   task automatic drain(input int b);
      int n;
      n = 0;
      while (sb[b].size() != 0 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_empty", 32'(sb[b].size()), 0);
   endtask

   always @(negedge clk) begin
      for (int b = 0; b < 2; b++) begin
         if (ack[b] || err[b]) begin
            check("ack_and_err", 32'(ack[b] & err[b]), 0);
            if (sb[b].size() == 0) begin
               check("unexpected_resp", 32'(sb[b].size()), 1);
            end else begin
               exp_t e;
               e = sb[b].pop_front();
               check("resp_err", 32'(err[b]), 32'(e.err));
               check("resp_ack", 32'(ack[b]), 32'(!e.err));
               check("resp_dat", rdat[b], e.dat);
               check("resp_cycle", 32'(cyc_cnt), 32'(e.due));
            end
         end else begin
            check("idle_dat", rdat[b], 0);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
         adr[i] = '0; wdat[i] = '0; sel[i] = '0;
      end
      #12;
      for (int i = 0; i < 2; i++) begin
         check("rst_ack", 32'(ack[i]), 0);
         check("rst_err", 32'(err[i]), 0);
         check("rst_dat", rdat[i], 0);
         check("rst_stall", 32'(stall[i]), 1);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("stall_after_rst_a", 32'(stall[0]), 0);
      check("stall_after_rst_b", 32'(stall[1]), 0);

      issue(0, 1'b1, A_BASE + 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
      issue(0, 1'b0, A_BASE + 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF);
      idle(0); drain(0);

      issue(0, 1'b1, A_BASE, 32'h11223344, 4'hF, 1'b0, 32'h0);
      issue(0, 1'b1, A_BASE, 32'h0000AA00, 4'b0010, 1'b0, 32'h0);
      issue(0, 1'b0, A_BASE, 32'h0, 4'h0, 1'b0, 32'h1122AA44);
      idle(0); drain(0);

      for (int i = 1; i < 8; i++) begin
         issue(0, 1'b1, A_BASE + 32'(4 * i), 32'hC0DE0000 | 32'(i), 4'hF, 1'b0, 32'h0);
      end
      idle(0); drain(0);
      s0 = stall_seen[0];
      for (int i = 0; i < 8; i++) begin
         issue(0, 1'b0, A_BASE + 32'(4 * i), 32'h0, 4'h0, 1'b0,
               (i == 0) ? 32'h1122AA44 : (32'hC0DE0000 | 32'(i)));
      end
      idle(0); drain(0);
      check("b2b_no_stall", 32'(stall_seen[0] - s0), 0);

      issue(0, 1'b0, A_BASE + 32'(1024 * 4), 32'h0, 4'hF, 1'b1, 32'h0);
      issue(0, 1'b0, A_BASE + 32'h2, 32'h0, 4'hF, 1'b1, 32'h0);
      issue(0, 1'b1, A_BASE, 32'hFFFFFFFF, 4'h0, 1'b1, 32'h0);
      issue(0, 1'b0, A_BASE - 32'h4, 32'h0, 4'hF, 1'b1, 32'h0);
      issue(0, 1'b1, A_BASE + 32'd4092, 32'h600D0001, 4'hF, 1'b0, 32'h0);
      issue(0, 1'b0, A_BASE + 32'd4092, 32'h0, 4'hF, 1'b0, 32'h600D0001);
      issue(0, 1'b0, A_BASE, 32'h0, 4'hF, 1'b0, 32'h1122AA44);
      idle(0); drain(0);

      issue(1, 1'b1, 32'h4, 32'h5A5A5A5A, 4'hF, 1'b0, 32'h0);
      issue(1, 1'b0, 32'h4, 32'h0, 4'hF, 1'b0, 32'h5A5A5A5A);
      issue(1, 1'b1, 32'h8, 32'h0BADF00D, 4'hF, 1'b0, 32'h0);
      issue(1, 1'b0, 32'h8, 32'h0, 4'hF, 1'b0, 32'h0BADF00D);
      idle(1); drain(1);

      issue(0, 1'b0, A_BASE, 32'h0, 4'hF, 1'b0, 32'h1122AA44);
      issue(0, 1'b0, A_BASE + 32'h4, 32'h0, 4'hF, 1'b0, 32'hC0DE0001);
      issue(0, 1'b0, A_BASE + 32'h8, 32'h0, 4'hF, 1'b0, 32'hC0DE0002);
      cyc[0] = 1'b0; stb[0] = 1'b0;
      @(posedge clk);
      #1;
      check("drop_pending", 32'(sb[0].size()), 1);
      sb[0].delete();
      check("drop_stall", 32'(stall[0]), 0);
      check("drop_outstanding", 32'(u_a.cnt_q), 0);
      repeat (4) @(posedge clk);
      #1;

      issue(0, 1'b0, A_BASE, 32'h0, 4'hF, 1'b0, 32'h1122AA44);
      issue(0, 1'b0, A_BASE + 32'h4, 32'h0, 4'hF, 1'b0, 32'hC0DE0001);
      check("pre_rst_ack", 32'(ack[0]), 1);
      rst_n = 1'b0;
      #1;
      check("async_rst_ack", 32'(ack[0]), 0);
      check("async_rst_err", 32'(err[0]), 0);
      check("async_rst_dat", rdat[0], 0);
      check("async_rst_stall", 32'(stall[0]), 1);
      sb[0].delete();
      idle(0);
      @(negedge clk);
      check("rst_hold_stall", 32'(stall[0]), 1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_release_stall", 32'(stall[0]), 0);
      issue(0, 1'b0, A_BASE + 32'h4, 32'h0, 4'hF, 1'b0, 32'hC0DE0001);
      idle(0); drain(0);
      repeat (3) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
